ifetch: RTL and testbench

Instruction fetch unit: the requesting end of the ICache read port. It walks a byte program counter, issues halfword reads to the ICache, captures the one-cycle-late `data`, and buffers the halfwords in a small FIFO. It presents in-order instructions to decode over a valid/ready handshake, and flushes and restarts on a branch redirect.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 52 +++++
 rtl/ifetch.sv | 114 +++++++++++
 tb/tb_ifetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths, Thumb-32 prefix encodings and the fetch buffer entry type.
package ifetch_pkg;

  localparam int PC_W = 32;
  localparam int HW_W = 16;

  // Top five bits of the first halfword of a 32-bit Thumb instruction
  localparam logic [4:0] T32_PFX_A = 5'b11101;
  localparam logic [4:0] T32_PFX_B = 5'b11110;
  localparam logic [4:0] T32_PFX_C = 5'b11111;

  typedef struct packed {
    logic [HW_W-1:0] hw;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic is_t32_prefix(input logic [HW_W-1:0] hw);
    return (hw[15:11] == T32_PFX_A) || (hw[15:11] == T32_PFX_B) ||
           (hw[15:11] == T32_PFX_C);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Halfword buffer: sync FIFO with async reset, flush, pop-1/pop-2 and two read ports.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wr_data,
  input  logic                     pop1,
  input  logic                     pop2,
  output fetch_entry_t             head,
  output fetch_entry_t             head1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] pop_n;
  fetch_entry_t  mem [DEPTH];

  assign pop_n = pop2 ? CW'(2) : (pop1 ? CW'(1) : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // Depth is a power of two, so pointer wrap is plain modular add
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      count  <= count + CW'(push) - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head  = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues halfword ICache reads, buffers them, feeds decode.
// Define IFETCH_THUMB32_EN to pair 32-bit Thumb prefixes into one instruction.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ic_not_enable,
  output logic [31:0] ic_index,
  input  logic [15:0] ic_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is32
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CW + 1;

  logic [PC_W-1:0] fetch_pc, pending_pc;
  logic            pending;
  logic [CW-1:0]   count;
  logic [IW-1:0]   inflight;
  logic            issue, push, fire, pop1, pop2, head_prefix;
  fetch_entry_t    head, head1, push_entry;

  // Capacity reserves room for the in-flight read; pops are not credited
  assign inflight = IW'(count) + IW'(pending);
  assign issue    = !reset && !redirect && (inflight < IW'(FIFO_DEPTH));

  assign ic_not_enable = !issue;
  assign ic_index      = reset ? 32'h0 : {1'b0, fetch_pc[31:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= {RESET_PC[31:1], 1'b0};
      pending    <= 1'b0;
      pending_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:1], 1'b0};
      pending  <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd2;
      end
    end
  end

  assign push       = pending && !redirect;
  assign push_entry = '{hw: ic_data, pc: pending_pc};

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect),
    .push    (push),
    .wr_data (push_entry),
    .pop1    (pop1),
    .pop2    (pop2),
    .head    (head),
    .head1   (head1),
    .count   (count)
  );

  assign head_prefix = is_t32_prefix(head.hw);

  always_comb begin
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    instr_is32  = 1'b0;
`ifdef IFETCH_THUMB32_EN
    if (head_prefix) begin
      // A prefix waits until its second halfword is buffered
      if (count >= CW'(2)) begin
        instr_valid = 1'b1;
        instr       = {head.hw, head1.hw};
        instr_pc    = head.pc;
        instr_is32  = 1'b1;
      end
    end else if (count != '0) begin
      instr_valid = 1'b1;
      instr       = {16'h0, head.hw};
      instr_pc    = head.pc;
    end
`else
    if (count != '0) begin
      instr_valid = 1'b1;
      instr       = {16'h0, head.hw};
      instr_pc    = head.pc;
    end
`endif
    fire = instr_valid && instr_ready && !redirect;
    pop2 = fire && instr_is32;
    pop1 = fire && !instr_is32;
  end

`ifdef IFETCH_THUMB32_EN
  logic unused_bits;
  assign unused_bits = redirect_pc[0];
`else
  logic unused_bits;
  assign unused_bits = ^{head1, head_prefix, redirect_pc[0]};
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: vector table for stream+redirect, hand sequences for corners.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_not_enable;
  logic [31:0] ic_index;
  logic [15:0] ic_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is32;

  int checks = 0;
  int errors = 0;

  ifetch #(.FIFO_DEPTH(4), .RESET_PC(32'h20)) dut (
    .clk           (clk),
    .reset         (reset),
    .ic_not_enable (ic_not_enable),
    .ic_index      (ic_index),
    .ic_data       (ic_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_is32    (instr_is32)
  );

  always #5 clk = ~clk;

  // Cache image: a Thumb pair plus a 16-bit op at byte 0x40, otherwise index with bit 15 clear
  function automatic logic [15:0] memf(input logic [31:0] i);
    case (i)
      32'h20:  return 16'hF000;
      32'h21:  return 16'hF800;
      32'h22:  return 16'h4770;
      default: return {1'b0, i[14:0]};
    endcase
  endfunction

  always @(posedge clk) if (!ic_not_enable) ic_data <= memf(ic_index);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic rdy);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_ne;
    logic [31:0] e_idx;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [31:0] w_idx [1:3];
    logic [31:0] w_pc  [3:5];
    logic [31:0] w_ins [3:5];

    vt[0] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10, 1'b0, 32'h0,  32'h0};
    vt[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h11, 1'b0, 32'h0,  32'h0};
    vt[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h12, 1'b1, 32'h10, 32'h20};
    vt[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h13, 1'b1, 32'h11, 32'h22};
    vt[4] = '{1'b1, 32'h101, 1'b1, 1'b1, 32'h14, 1'b1, 32'h12, 32'h24};
    vt[5] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h80, 1'b0, 32'h0,  32'h0};
    vt[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h81, 1'b0, 32'h0,  32'h0};
    vt[7] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h82, 1'b1, 32'h80, 32'h100};
    vt[8] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h83, 1'b1, 32'h81, 32'h102};

    // Reset state while reset is held
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    #2;
    chk("rst_ne",    32'(ic_not_enable), 32'h1);
    chk("rst_idx",   ic_index,           32'h0);
    chk("rst_valid", 32'(instr_valid),   32'h0);
    chk("rst_instr", instr,              32'h0);
    chk("rst_pc",    instr_pc,           32'h0);
    chk("rst_is32",  32'(instr_is32),    32'h0);

    // Stream from RESET_PC, then redirect to 0x101 with a read in flight
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      redirect = vt[i].redir; redirect_pc = vt[i].rpc; instr_ready = vt[i].rdy;
      #1;
      chk($sformatf("v%0d_ne", i),    32'(ic_not_enable), 32'(vt[i].e_ne));
      chk($sformatf("v%0d_idx", i),   ic_index,           vt[i].e_idx);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid),   32'(vt[i].e_v));
      if (vt[i].e_v) begin
        chk($sformatf("v%0d_instr", i), instr,            vt[i].e_instr);
        chk($sformatf("v%0d_pc", i),    instr_pc,         vt[i].e_pc);
        chk($sformatf("v%0d_is32", i),  32'(instr_is32),  32'h0);
      end
      @(negedge clk);
    end
    redirect = 1'b0;

    // Backpressure: four halfwords buffered or in flight stops issue
    do_reset(1'b0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("bp%0d_ne", c), 32'(ic_not_enable), (c >= 4) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("bp_drain%0d_valid", j), 32'(instr_valid), 32'h1);
      chk($sformatf("bp_drain%0d_pc", j),    instr_pc,         32'h20 + 32'(2 * j));
      chk($sformatf("bp_drain%0d_instr", j), instr,            32'h10 + 32'(j));
      @(negedge clk);
    end

    // Redirect near the top of the address space; fetch wraps to 0
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    w_idx[1] = 32'h7FFF_FFFE; w_idx[2] = 32'h7FFF_FFFF; w_idx[3] = 32'h0;
    w_pc[3]  = 32'hFFFF_FFFC; w_pc[4]  = 32'hFFFF_FFFE; w_pc[5]  = 32'h0;
    w_ins[3] = 32'h7FFE;      w_ins[4] = 32'h7FFF;      w_ins[5] = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k == 1) chk("wrap_valid_r1", 32'(instr_valid), 32'h0);
      if (k <= 3) chk($sformatf("wrap_idx_r%0d", k), ic_index, w_idx[k]);
      if (k >= 3) begin
        chk($sformatf("wrap_valid_r%0d", k), 32'(instr_valid), 32'h1);
        chk($sformatf("wrap_pc_r%0d", k),    instr_pc,         w_pc[k]);
        chk($sformatf("wrap_instr_r%0d", k), instr,            w_ins[k]);
      end
      @(negedge clk);
    end

    // Thumb pair 0xF000,0xF800 followed by 0x4770 at byte 0x40
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k == 1) chk("t32_idx_r1", ic_index, 32'h20);
`ifdef IFETCH_THUMB32_EN
      if (k == 3) chk("t32_valid_r3", 32'(instr_valid), 32'h0);
      if (k == 4) begin
        chk("t32_valid_r4", 32'(instr_valid), 32'h1);
        chk("t32_instr_r4", instr,            32'hF000_F800);
        chk("t32_is32_r4",  32'(instr_is32),  32'h1);
        chk("t32_pc_r4",    instr_pc,         32'h40);
      end
      if (k == 5) begin
        chk("t32_valid_r5", 32'(instr_valid), 32'h1);
        chk("t32_instr_r5", instr,            32'h0000_4770);
        chk("t32_is32_r5",  32'(instr_is32),  32'h0);
        chk("t32_pc_r5",    instr_pc,         32'h44);
      end
`else
      if (k >= 3) begin
        chk($sformatf("t16_valid_r%0d", k), 32'(instr_valid), 32'h1);
        chk($sformatf("t16_pc_r%0d", k),    instr_pc,         32'h40 + 32'(2 * (k - 3)));
        chk($sformatf("t16_instr_r%0d", k), instr,
            (k == 3) ? 32'hF000 : ((k == 4) ? 32'hF800 : 32'h4770));
        chk($sformatf("t16_is32_r%0d", k),  32'(instr_is32),  32'h0);
      end
`endif
      @(negedge clk);
    end

    // Reset pulse between clock edges while the stream is running
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ne",    32'(ic_not_enable), 32'h1);
    chk("arst_idx",   ic_index,           32'h0);
    chk("arst_valid", 32'(instr_valid),   32'h0);
    chk("arst_instr", instr,              32'h0);
    chk("arst_pc",    instr_pc,           32'h0);
    chk("arst_is32",  32'(instr_is32),    32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_refetch_idx",  ic_index,           32'h10);
    chk("arst_refetch_ne",   32'(ic_not_enable), 32'h0);
    chk("arst_refetch_v0",   32'(instr_valid),   32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("arst_first_valid", 32'(instr_valid), 32'h1);
    chk("arst_first_pc",    instr_pc,         32'h20);
    chk("arst_first_instr", instr,            32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
